// File: rtl/compare_sequencer.sv
// Count/limit sequencer: steps through NSLOT programmable phase limits, pulsing o_tick per phase.
// Optional one-shot mode (stop after the last slot) is enabled by defining SEQ_ONESHOT_EN.
module compare_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int NSLOT       = 4,
  parameter int LIMIT_RESET = 9
) (
  input  logic                     clock,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic                     i_limit_wr,
  input  logic [$clog2(NSLOT)-1:0] i_limit_sel,
  input  logic [DATA_WIDTH-1:0]    i_limit_data,
  output logic [DATA_WIDTH-1:0]    o_count,
  output logic [$clog2(NSLOT)-1:0] o_slot,
  output logic                     o_tick,
  output logic [$clog2(NSLOT)-1:0] o_tick_slot,
  output logic                     o_busy
);

  localparam int SLOT_W = $clog2(NSLOT);
  localparam logic [SLOT_W-1:0]     SLOT_ONE  = SLOT_W'(1);
  localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(NSLOT - 1);
  localparam logic [DATA_WIDTH-1:0] COUNT_ONE = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] LIM_INIT  = DATA_WIDTH'(LIMIT_RESET);

`ifdef SEQ_ONESHOT_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1} state_t;
`endif

  state_t                  state_r, state_n_s;
  logic [DATA_WIDTH-1:0]   count_r, count_n_s;
  logic [SLOT_W-1:0]       slot_r, slot_n_s;
  logic                    tick_r, tick_n_s;
  logic [SLOT_W-1:0]       tick_slot_r, tick_slot_n_s;
  logic                    busy_r;
  logic [DATA_WIDTH-1:0]   limit_r [NSLOT];
  logic                    match_s;

  // Compare runs on registered values, so a same-cycle limit write is not yet visible.
  assign match_s = (count_r >= limit_r[slot_r]);

  // Limit bank: reset to LIMIT_RESET, written from the host port in any state.
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      for (int i = 0; i < NSLOT; i++) begin
        limit_r[i] <= LIM_INIT;
      end
    end else if (i_limit_wr) begin
      limit_r[i_limit_sel] <= i_limit_data;
    end
  end

  // Next-state and next-output decode; disable overrides a match.
  always_comb begin
    state_n_s     = state_r;
    count_n_s     = '0;
    slot_n_s      = '0;
    tick_n_s      = 1'b0;
    tick_slot_n_s = '0;
    case (state_r)
      ST_IDLE: begin
        if (i_enable) begin
          state_n_s = ST_RUN;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!i_enable) begin
          state_n_s = ST_IDLE;
        end else if (match_s) begin
          tick_n_s      = 1'b1;
          tick_slot_n_s = slot_r;
`ifdef SEQ_ONESHOT_EN
          if (slot_r == SLOT_LAST) begin
            state_n_s = ST_DONE;
          end else begin
            slot_n_s = slot_r + SLOT_ONE;
          end
`else
          slot_n_s = slot_r + SLOT_ONE;
`endif
        end else begin
          count_n_s = count_r + COUNT_ONE;
          slot_n_s  = slot_r;
        end
      end
`ifdef SEQ_ONESHOT_EN
      ST_DONE: begin
        if (!i_enable) begin
          state_n_s = ST_IDLE;
        end else begin
          state_n_s = ST_DONE;
        end
      end
`endif
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; busy is derived from the next state so it tracks state_r.
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      state_r     <= ST_IDLE;
      count_r     <= '0;
      slot_r      <= '0;
      tick_r      <= 1'b0;
      tick_slot_r <= '0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      count_r     <= count_n_s;
      slot_r      <= slot_n_s;
      tick_r      <= tick_n_s;
      tick_slot_r <= tick_slot_n_s;
      busy_r      <= (state_n_s == ST_RUN);
    end
  end

  assign o_count     = count_r;
  assign o_slot      = slot_r;
  assign o_tick      = tick_r;
  assign o_tick_slot = tick_slot_r;
  assign o_busy      = busy_r;

  // Unused when the last-slot compare is compiled out.
  logic unused_s;
  assign unused_s = ^SLOT_LAST;

endmodule
